reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 118 +++++++++++
 tb/tb_reorder_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks entries done on completion,
// and retires at most one done head entry per cycle onto registered ret_* outputs.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_has_rd,
  input  logic [4:0]        alloc_rd,
  input  logic [PREG_W-1:0] alloc_pd,
  input  logic [PREG_W-1:0] alloc_old_pd,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cmp_valid,
  input  logic [IDX_W-1:0]  cmp_idx,
  input  logic [31:0]       cmp_value,
  output logic              ret_valid,
  output logic              ret_has_rd,
  output logic [4:0]        ret_rd,
  output logic [PREG_W-1:0] ret_pd,
  output logic [PREG_W-1:0] ret_old_pd,
  output logic [31:0]       ret_value,
  output logic [IDX_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_done;
  logic              ent_has_rd [DEPTH];
  logic [4:0]        ent_rd     [DEPTH];
  logic [PREG_W-1:0] ent_pd     [DEPTH];
  logic [PREG_W-1:0] ent_old_pd [DEPTH];
  logic [31:0]       ent_value  [DEPTH];

  logic alloc_fire;
  logic cmp_fire;
  logic ret_fire;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign alloc_ready = !full && !flush;
  assign alloc_idx   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cmp_fire    = cmp_valid && ent_valid[cmp_idx];
  // Retire looks only at stored state, so a completion on this edge waits a cycle.
  assign ret_fire    = ent_valid[head] && ent_done[head];

  // NOTE: every register in this block is sequential state, so only non-blocking
  // assignments are used; mixing in blocking ones would create read-order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_valid  <= '0;
      ent_done   <= '0;
      ret_valid  <= 1'b0;
      ret_has_rd <= 1'b0;
      ret_rd     <= '0;
      ret_pd     <= '0;
      ret_old_pd <= '0;
      ret_value  <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
      ret_valid <= 1'b0;
    end else begin
      ret_valid <= ret_fire;
      if (cmp_fire) ent_done[cmp_idx] <= 1'b1;
      // tail never aliases a valid entry while allocation is allowed, so these
      // writes cannot collide with completion or retire of the same slot.
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        tail            <= tail + 1'b1;
      end
      if (ret_fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
        ret_has_rd      <= ent_has_rd[head];
        ret_rd          <= ent_rd[head];
        ret_pd          <= ent_pd[head];
        ret_old_pd      <= ent_old_pd[head];
        ret_value       <= ent_value[head];
      end
      case ({alloc_fire, ret_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage is not reset; valid/done gate every use of it, and
  // leaving it unreset lets it map onto plain RAM without a clear sequence.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_has_rd[tail] <= alloc_has_rd;
      ent_rd[tail]     <= alloc_rd;
      ent_pd[tail]     <= alloc_pd;
      ent_old_pd[tail] <= alloc_old_pd;
    end
    if (cmp_fire) ent_value[cmp_idx] <= cmp_value;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retire, full/backpressure, wrap,
// stray completion, flush and asynchronous reset.
module tb_reorder_buffer;

  localparam int DEPTH  = 16;
  localparam int IDX_W  = 4;
  localparam int PREG_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_has_rd;
  logic [4:0]        alloc_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_old_pd;
  logic              alloc_ready;
  logic [IDX_W-1:0]  alloc_idx;
  logic              cmp_valid;
  logic [IDX_W-1:0]  cmp_idx;
  logic [31:0]       cmp_value;
  logic              ret_valid;
  logic              ret_has_rd;
  logic [4:0]        ret_rd;
  logic [PREG_W-1:0] ret_pd;
  logic [PREG_W-1:0] ret_old_pd;
  logic [31:0]       ret_value;
  logic [IDX_W:0]    count;
  logic              empty;
  logic              full;

  int total = 0;
  int bad   = 0;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_has_rd(alloc_has_rd),
    .alloc_rd    (alloc_rd),
    .alloc_pd    (alloc_pd),
    .alloc_old_pd(alloc_old_pd),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .cmp_valid   (cmp_valid),
    .cmp_idx     (cmp_idx),
    .cmp_value   (cmp_value),
    .ret_valid   (ret_valid),
    .ret_has_rd  (ret_has_rd),
    .ret_rd      (ret_rd),
    .ret_pd      (ret_pd),
    .ret_old_pd  (ret_old_pd),
    .ret_value   (ret_value),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alloc(input logic [4:0] rd, input logic [PREG_W-1:0] pd,
                             input logic [PREG_W-1:0] old_pd);
    alloc_valid  = 1'b1;
    alloc_has_rd = 1'b1;
    alloc_rd     = rd;
    alloc_pd     = pd;
    alloc_old_pd = old_pd;
  endtask

  task automatic drive_cmp(input int idx, input logic [31:0] value);
    cmp_valid = 1'b1;
    cmp_idx   = IDX_W'(idx);
    cmp_value = value;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_has_rd = 1'b0; alloc_rd = '0; alloc_pd = '0; alloc_old_pd = '0;
    cmp_valid = 1'b0; cmp_idx = '0; cmp_value = '0;

    // Reset state
    #12;
    check("rst_count", count, 0);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_ret_pd", ret_pd, 0);
    check("rst_empty", empty, 1);
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_idx", alloc_idx, 0);
    rst_n = 1'b1;
    tick();

    // Three allocations, completed out of order 2,1,0
    for (int i = 0; i < 3; i++) begin
      drive_alloc(5'(i + 1), PREG_W'(32 + i), PREG_W'(i));
      check("alloc3_idx", alloc_idx, i);
      tick();
    end
    alloc_valid = 1'b0;
    check("alloc3_count", count, 3);
    drive_cmp(2, 32'h200); tick();
    drive_cmp(1, 32'h100); tick();
    check("undone_head_waits", ret_valid, 0);
    drive_cmp(0, 32'h000); tick();
    cmp_valid = 1'b0;
    check("no_retire_on_cmp_edge", ret_valid, 0);
    tick();
    check("ret0_valid", ret_valid, 1);
    check("ret0_pd", ret_pd, 32);
    check("ret0_rd", ret_rd, 1);
    check("ret0_old_pd", ret_old_pd, 0);
    check("ret0_has_rd", ret_has_rd, 1);
    tick();
    check("ret1_valid", ret_valid, 1);
    check("ret1_pd", ret_pd, 33);
    check("ret1_value", ret_value, 32'h100);
    tick();
    check("ret2_valid", ret_valid, 1);
    check("ret2_pd", ret_pd, 34);
    check("ret2_value", ret_value, 32'h200);
    check("drain_count", count, 0);
    tick();
    check("idle_ret_valid", ret_valid, 0);
    check("idle_ret_pd_hold", ret_pd, 34);

    // Fill all 16 entries starting at index 3
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(5'(i), PREG_W'(i), PREG_W'(i + 40));
      check("fill_idx", alloc_idx, (i + 3) % DEPTH);
      tick();
    end
    check("full_flag", full, 1);
    check("full_alloc_ready", alloc_ready, 0);
    check("full_count", count, 16);
    check("full_tail", alloc_idx, 3);
    tick();
    check("over_alloc_count", count, 16);
    check("over_alloc_tail", alloc_idx, 3);

    // Full ROB, head completes, alloc_valid held high
    drive_cmp(3, 32'h33); tick();
    cmp_valid = 1'b0;
    check("full_retire_cycle_ready", alloc_ready, 0);
    tick();
    alloc_valid = 1'b0;
    check("full_retire_count", count, 15);
    check("full_retire_valid", ret_valid, 1);
    check("full_retire_pd", ret_pd, 0);
    check("full_retire_value", ret_value, 32'h33);
    check("full_retire_ready", alloc_ready, 1);

    flush = 1'b1;
    #1;
    check("flush_blocks_ready", alloc_ready, 0);
    tick();
    flush = 1'b0;
    check("flush15_count", count, 0);
    check("flush15_tail", alloc_idx, 0);
    check("flush15_ret_valid", ret_valid, 0);

    // Streaming allocate/complete/retire across the 15->0 wrap
    for (int k = 0; k < 20; k++) begin
      drive_alloc(5'(k), PREG_W'(k), PREG_W'(0));
      check("wrap_alloc_idx", alloc_idx, k % DEPTH);
      if (k >= 1) drive_cmp((k - 1) % DEPTH, 32'hA000 + 32'(k - 1));
      else cmp_valid = 1'b0;
      tick();
      if (k >= 2) begin
        check("wrap_ret_valid", ret_valid, 1);
        check("wrap_ret_value", ret_value, 32'hA000 + 32'(k - 2));
        check("wrap_ret_pd", ret_pd, k - 2);
        check("wrap_count", count, 2);
      end
    end
    alloc_valid = 1'b0;
    drive_cmp(19 % DEPTH, 32'hA013); tick();
    cmp_valid = 1'b0;
    check("wrap_ret18_value", ret_value, 32'hA012);
    tick();
    check("wrap_ret19_value", ret_value, 32'hA013);
    check("wrap_ret19_pd", ret_pd, 19);
    check("wrap_drain_count", count, 0);

    // Stray completion to an invalid index, then flush with 5 entries valid
    for (int i = 0; i < 5; i++) begin
      drive_alloc(5'(i), PREG_W'(50 + i), PREG_W'(0));
      tick();
    end
    alloc_valid = 1'b0;
    check("five_count", count, 5);
    drive_cmp(10, 32'hDEAD); tick();
    cmp_valid = 1'b0;
    tick();
    check("stray_cmp_ret_valid", ret_valid, 0);
    check("stray_cmp_count", count, 5);
    drive_cmp(4, 32'h44); tick();
    cmp_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush5_count", count, 0);
    check("flush5_ret_valid", ret_valid, 0);
    tick();
    check("flush5_ret_valid_later", ret_valid, 0);
    check("flush5_empty", empty, 1);

    // Asynchronous reset while a retire is being presented
    for (int i = 0; i < 4; i++) begin
      drive_alloc(5'(i), PREG_W'(20 + i), PREG_W'(0));
      tick();
    end
    alloc_valid = 1'b0;
    drive_cmp(0, 32'h77); tick();
    cmp_valid = 1'b0;
    tick();
    check("prereset_ret_valid", ret_valid, 1);
    check("prereset_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ret_valid", ret_valid, 0);
    check("async_rst_count", count, 0);
    check("async_rst_ret_pd", ret_pd, 0);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", alloc_ready, 1);
    drive_alloc(5'd9, PREG_W'(9), PREG_W'(1));
    check("post_rst_alloc_idx", alloc_idx, 0);
    tick();
    alloc_valid = 1'b0;
    check("post_rst_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
